// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86 definitions: PC width, architectural status codes
//                and the PC/stat controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Architectural program counter width
    localparam int unsigned PC_W = 64;

    // Y86 status codes, shared with the rest of the core
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Controller state encoding
    localparam int unsigned STATE_W       = 2;
    localparam logic [1:0]  STATE_PRIME   = 2'd0;
    localparam logic [1:0]  STATE_RUN     = 2'd1;
    localparam logic [1:0]  STATE_STOPPED = 2'd2;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/ctr32_en.sv
`default_nettype none
// ============================================================================
//  Module      : ctr32_en
//  Description : 32-bit up counter with asynchronous active-high reset and a
//                count enable. Wraps modulo 2^32.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctr32_en (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    // Count one per enabled edge; natural overflow gives the modulo wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 32'd0;
        end else if (i_en) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule : ctr32_en
`default_nettype wire

// File: rtl/pc_stat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stat_ctrl
//  Description : Architectural PC register and processor status controller
//                for the sequential Y86 core. Holds the PC fed to fetch,
//                decides commit enable, stop/finish, status code, watchdog
//                timeout and the cycle/retire counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_stat_ctrl
    import y86_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 64'd0,
    parameter logic [31:0]     MAX_CYCLES = 32'd1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_new,
    input  logic            halt,
    input  logic            instruct_invalid,
    input  logic            imem_error,
    input  logic            dmem_error,
    output logic [PC_W-1:0] pc_val,
    output logic [2:0]      stat,
    output logic            run,
    output logic            done,
    output logic            timeout,
    output logic [31:0]     cycle_count,
    output logic [31:0]     retired_count
);

    logic [STATE_W-1:0] r_state;
    logic [PC_W-1:0]    r_pc;
    logic [2:0]         r_stat;
    logic               r_done;
    logic               r_timeout;

    logic               w_in_run;
    logic               w_any_fault;
    logic               w_wd_hit;
    logic               w_retire;
    logic [31:0]        w_cycle_count;
    logic [31:0]        w_retired_count;

    // Decode of the current cycle: faults, watchdog and retire qualification
    always_comb begin
        w_in_run    = (r_state == STATE_RUN);
        w_any_fault = imem_error | instruct_invalid | dmem_error;
        // cycle_count is the number of RUN edges already taken, so the
        // watchdog fires on the edge that would make it reach MAX_CYCLES
        w_wd_hit    = (MAX_CYCLES != 32'd0) &&
                      (w_cycle_count == (MAX_CYCLES - 32'd1));
        // A halt retires even when the watchdog coincides; faults never do,
        // and a bare watchdog stop does not advance the PC so it retires nothing
        w_retire    = w_in_run && !w_any_fault && (halt || !w_wd_hit);
    end

    // Commit enable: faulting or halting instructions must not commit;
    // the watchdog deliberately lets the final instruction commit
    assign run = w_in_run && !w_any_fault && !halt;

    // Controller FSM with registered PC, status, done and timeout
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= STATE_PRIME;
            r_pc      <= RESET_PC;
            r_stat    <= STAT_AOK;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                STATE_PRIME: begin
                    // Give fetch one cycle to settle on RESET_PC
                    r_state <= STATE_RUN;
                end
                STATE_RUN: begin
                    if (imem_error) begin
                        r_stat  <= STAT_ADR;
                        r_done  <= 1'b1;
                        r_state <= STATE_STOPPED;
                    end else if (instruct_invalid) begin
                        r_stat  <= STAT_INS;
                        r_done  <= 1'b1;
                        r_state <= STATE_STOPPED;
                    end else if (dmem_error) begin
                        r_stat  <= STAT_ADR;
                        r_done  <= 1'b1;
                        r_state <= STATE_STOPPED;
                    end else if (halt) begin
                        r_stat  <= STAT_HLT;
                        r_done  <= 1'b1;
                        r_state <= STATE_STOPPED;
                    end else if (w_wd_hit) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= STATE_STOPPED;
                    end else begin
                        r_pc <= pc_new;
                    end
                end
                STATE_STOPPED: begin
                    // Terminal: everything held until reset
                end
                default: begin
                    // Unused encoding: park safely as a stopped machine
                    r_state <= STATE_STOPPED;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    // RUN-cycle counter, including the stopping edge
    ctr32_en u_cycle_ctr (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_in_run),
        .o_count (w_cycle_count)
    );

    // Retired-instruction counter
    ctr32_en u_retire_ctr (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_retire),
        .o_count (w_retired_count)
    );

    assign pc_val        = r_pc;
    assign stat          = r_stat;
    assign done          = r_done;
    assign timeout       = r_timeout;
    assign cycle_count   = w_cycle_count;
    assign retired_count = w_retired_count;

endmodule : pc_stat_ctrl
`default_nettype wire

// File: tb/tb_pc_stat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_stat_ctrl
//  Description : Self-checking bench for pc_stat_ctrl. Vector tables of
//                {inputs, expected outputs} are applied one per cycle; each
//                expectation is queued when its stimulus is driven and popped
//                when the DUT's registered outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stat_ctrl;

    localparam logic [63:0] C_RESET_PC = 64'd2;
    localparam logic [31:0] C_MAX_CYC  = 32'd8;

    typedef struct {
        logic [63:0] pc_new;
        logic        halt;
        logic        inv;
        logic        imem;
        logic        dmem;
        logic        exp_run;
        logic [63:0] exp_pc;
        logic [2:0]  exp_stat;
        logic        exp_done;
        logic        exp_to;
        logic [31:0] exp_cyc;
        logic [31:0] exp_ret;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [63:0] pc_new;
    logic        halt;
    logic        instruct_invalid;
    logic        imem_error;
    logic        dmem_error;
    logic [63:0] pc_val;
    logic [2:0]  stat;
    logic        run;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;

    int    errors = 0;
    int    checks = 0;
    string phase  = "init";
    vec_t  vecs[$];
    vec_t  sb[$];

    pc_stat_ctrl #(
        .RESET_PC   (C_RESET_PC),
        .MAX_CYCLES (C_MAX_CYC)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pc_new           (pc_new),
        .halt             (halt),
        .instruct_invalid (instruct_invalid),
        .imem_error       (imem_error),
        .dmem_error       (dmem_error),
        .pc_val           (pc_val),
        .stat             (stat),
        .run              (run),
        .done             (done),
        .timeout          (timeout),
        .cycle_count      (cycle_count),
        .retired_count    (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [63:0] pn, input logic h, input logic inv,
                           input logic im, input logic dm, input logic er,
                           input logic [63:0] ep, input logic [2:0] es,
                           input logic ed, input logic et,
                           input logic [31:0] ec, input logic [31:0] eret);
        vec_t v;
        v.pc_new = pn;  v.halt = h;  v.inv = inv;  v.imem = im;  v.dmem = dm;
        v.exp_run = er; v.exp_pc = ep; v.exp_stat = es; v.exp_done = ed;
        v.exp_to = et;  v.exp_cyc = ec; v.exp_ret = eret;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        pc_new = 64'd0; halt = 1'b0; instruct_invalid = 1'b0;
        imem_error = 1'b0; dmem_error = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},   pc_val,        C_RESET_PC);
        chk({tag, "_stat"}, {61'd0, stat}, 64'd1);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_to"},   {63'd0, timeout}, 64'd0);
        chk({tag, "_cyc"},  {32'd0, cycle_count},   64'd0);
        chk({tag, "_ret"},  {32'd0, retired_count}, 64'd0);
        chk({tag, "_run"},  {63'd0, run}, 64'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after release
    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        #1;
        chk_reset_vals("rst");
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic apply(input vec_t v);
        vec_t e;
        pc_new = v.pc_new; halt = v.halt; instruct_invalid = v.inv;
        imem_error = v.imem; dmem_error = v.dmem;
        sb.push_back(v);
        #1;
        chk("run", {63'd0, run}, {63'd0, v.exp_run});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("pc",   pc_val,            e.exp_pc);
        chk("stat", {61'd0, stat},     {61'd0, e.exp_stat});
        chk("done", {63'd0, done},     {63'd0, e.exp_done});
        chk("to",   {63'd0, timeout},  {63'd0, e.exp_to});
        chk("cyc",  {32'd0, cycle_count},   {32'd0, e.exp_cyc});
        chk("ret",  {32'd0, retired_count}, {32'd0, e.exp_ret});
        @(negedge clock);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end
        vecs.delete();
    endtask

    // PRIME cycle: no commit, PC stays at RESET_PC, counters frozen
    task automatic add_prime();
        add_vec(64'hdead, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RESET_PC, 3'd1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // k-th normal RUN cycle (k from 1): PC moves from 2+10(k-1) to 2+10k
    task automatic add_normal(input int k);
        logic [63:0] nxt;
        nxt = C_RESET_PC + 64'(10 * k);
        add_vec(nxt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, nxt, 3'd1, 1'b0, 1'b0, 32'(k), 32'(k));
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        @(negedge clock);

        // Five clean RUN cycles
        phase = "seq5";
        do_reset();
        add_prime();
        for (int k = 1; k <= 5; k++) add_normal(k);
        run_vecs();

        // Halt on the third RUN cycle, then idle inputs toggling while stopped
        phase = "halt";
        do_reset();
        add_prime();
        add_normal(1);
        add_normal(2);
        add_vec(64'd32, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd22, 3'd2, 1'b1, 1'b0, 32'd3, 32'd3);
        run_vecs();
        phase = "stopped";
        for (int i = 0; i < 10; i++) begin
            logic [3:0] b;
            b = 4'(i);
            add_vec(64'(100 + 4 * i), b[0], 1'b0, 1'b0, b[1], 1'b0,
                    64'd22, 3'd2, 1'b1, 1'b0, 32'd3, 32'd3);
        end
        run_vecs();

        // Invalid instruction together with a data-memory error: INS wins
        phase = "ins_dmem";
        do_reset();
        add_prime();
        add_vec(64'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd2, 3'd4, 1'b1, 1'b0, 32'd1, 32'd0);
        run_vecs();

        // Instruction-memory error together with halt: ADR, no retire
        phase = "imem_halt";
        do_reset();
        add_prime();
        add_normal(1);
        add_vec(64'd22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd12, 3'd3, 1'b1, 1'b0, 32'd2, 32'd1);
        run_vecs();

        // Data-memory error alone
        phase = "dmem";
        do_reset();
        add_prime();
        add_vec(64'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd2, 3'd3, 1'b1, 1'b0, 32'd1, 32'd0);
        run_vecs();

        // Watchdog: eighth RUN edge stops with timeout, final insn commits
        phase = "watchdog";
        do_reset();
        add_prime();
        for (int k = 1; k <= 7; k++) add_normal(k);
        add_vec(64'd82, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd72, 3'd1, 1'b1, 1'b1, 32'd8, 32'd7);
        add_vec(64'd99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd72, 3'd1, 1'b1, 1'b1, 32'd8, 32'd7);
        run_vecs();

        // Halt on the watchdog edge: the real stop wins, no timeout
        phase = "wd_halt";
        do_reset();
        add_prime();
        for (int k = 1; k <= 7; k++) add_normal(k);
        add_vec(64'd82, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd72, 3'd2, 1'b1, 1'b0, 32'd8, 32'd8);
        run_vecs();

        // Asynchronous reset between edges mid-RUN, then restart from RESET_PC
        phase = "async_rst";
        do_reset();
        add_prime();
        add_normal(1);
        add_normal(2);
        run_vecs();
        pc_new = 64'd55;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        @(negedge clock);
        reset = 1'b0;
        add_prime();
        add_normal(1);
        run_vecs();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d leftover expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

endmodule : tb_pc_stat_ctrl
`default_nettype wire
